// File: rtl/fifo_uart_drain.sv
// Purpose: pops bytes from an 8-bit FIFO and serialises them as 8N1 UART frames, LSB first.
// Latency: start bit begins 3 cycles after the pop decision; each frame lasts 10*CLK_PER_BIT cycles.
// Backpressure: pops only in IDLE, only when tx_en is high and the FIFO is non-empty, at most one byte per frame.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   tx_en          permission to start new frames (sampled in IDLE only)
//   left_sig       FIFO free-slot count; DEEP (or more) means empty
//   read_req       one-cycle FIFO pop request
//   FIFO_read_data FIFO output register, valid the cycle after read_req
//   tx_out         serial line, idle high
//   busy           high whenever the FSM is not in IDLE
//   byte_done      one-cycle pulse on the last cycle of each stop bit
module fifo_uart_drain #(
    parameter int DEEP        = 4,
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [2:0] left_sig,
    output logic       read_req,
    input  logic [7:0] FIFO_read_data,
    output logic       tx_out,
    output logic       busy,
    output logic       byte_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);
    // byte_done is registered, so it is set one cycle before the stop bit's last cycle
    localparam logic [15:0] BAUD_PRE  = 16'(CLK_PER_BIT - 2);
    localparam logic [2:0]  DEEP_L    = 3'(DEEP);

    state_t      state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] baud_cnt_q;
    logic        read_req_q;
    logic        tx_q;
    logic        busy_q;
    logic        byte_done_q;

    logic        bit_end;
    logic        fifo_has_data;

    assign bit_end       = (baud_cnt_q == BAUD_LAST);
    // Any count at or above DEEP (including illegal values) reads as empty
    assign fifo_has_data = (left_sig < DEEP_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            baud_cnt_q  <= 16'd0;
            read_req_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_en && fifo_has_data) begin
                        read_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    read_req_q <= 1'b0;
                    state_q    <= S_LOAD;
                end
                S_LOAD: begin
                    // FIFO output register holds the popped byte during this cycle
                    shift_q    <= FIFO_read_data;
                    tx_q       <= 1'b0;
                    bit_cnt_q  <= 3'd0;
                    baud_cnt_q <= 16'd0;
                    state_q    <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt_q <= 16'd0;
                        tx_q       <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= 16'd0;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt_q <= 16'd0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                        if (baud_cnt_q == BAUD_PRE) begin
                            byte_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    read_req_q <= 1'b0;
                    tx_q       <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign read_req  = read_req_q;
    assign tx_out    = tx_q;
    assign busy      = busy_q;
    assign byte_done = byte_done_q;

endmodule
